instr_encoder: RTL and testbench

Instruction encoder and loader: the write-side counterpart of the processor's opcode decoder. It accepts field-level instruction requests over a valid/ready handshake and packs each into a 32-bit word in the processor ISA format (opcode in [31:27]). It buffers the words in a small FIFO and writes them sequentially into instruction memory through a shared write port that can be held off. Used by the program-load path and by test infrastructure to fill imem before the core is released from reset.

---
 rtl/isa_pkg.sv | 83 ++++++++
 rtl/instr_encoder_if.sv | 23 ++
 rtl/instr_fifo.sv | 46 ++++
 rtl/instr_encoder.sv | 136 +++++++++++++
 tb/tb_instr_encoder.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA opcodes, instruction formats, field positions and loader states
package isa_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_I02  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_I06  = 5'b00110;
    localparam logic [4:0] OP_I07  = 5'b00111;
    localparam logic [4:0] OP_I08  = 5'b01000;
    localparam logic [4:0] OP_J15  = 5'b10101;
    localparam logic [4:0] OP_J16  = 5'b10110;

    localparam int OP_LSB     = 27;
    localparam int RD_LSB     = 22;
    localparam int RS_LSB     = 17;
    localparam int RT_LSB     = 12;
    localparam int SHAMT_LSB  = 7;
    localparam int ALUOP_LSB  = 2;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_LSB = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_JI,
        FMT_JII,
        FMT_ILLEGAL
    } fmt_e;

    function automatic fmt_e op_format(input logic [4:0] op);
        case (op)
            OP_ALU:                                 return FMT_R;
            OP_ADDI, OP_I07, OP_I08, OP_I02, OP_I06: return FMT_I;
            OP_J, OP_JAL, OP_J16, OP_J15:           return FMT_JI;
            OP_JR:                                  return FMT_JII;
            default:                                return FMT_ILLEGAL;
        endcase
    endfunction

    function automatic logic [31:0] encode_word(
        input fmt_e        fmt,
        input logic [4:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  shamt,
        input logic [4:0]  aluop,
        input logic [16:0] imm,
        input logic [26:0] target
    );
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 5] = op;
        case (fmt)
            FMT_R: begin
                w[RD_LSB +: 5]    = rd;
                w[RS_LSB +: 5]    = rs;
                w[RT_LSB +: 5]    = rt;
                w[SHAMT_LSB +: 5] = shamt;
                w[ALUOP_LSB +: 5] = aluop;
            end
            FMT_I: begin
                w[RD_LSB +: 5]   = rd;
                w[RS_LSB +: 5]   = rs;
                w[IMM_LSB +: 17] = imm;
            end
            FMT_JI:  w[TARGET_LSB +: 27] = target;
            FMT_JII: w[RD_LSB +: 5] = rd;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-level instruction request bus with valid/ready handshake
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [16:0] imm;
    logic [26:0] target;

    modport master (
        output req_valid, op, rd, rs, rt, shamt, aluop, imm, target,
        input  req_ready
    );

    modport slave (
        input  req_valid, op, rd, rs, rt, shamt, aluop, imm, target,
        output req_ready
    );
endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO with flush holding encoded words ahead of imem
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction requests into ISA words and loads them into imem
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    instr_encoder_if.slave    req,
    input  logic              mem_hold,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

    logic [2:0]        state;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              acc_last;

    fmt_e        fmt;
    logic        legal;
    logic [31:0] word;
    logic        accept;
    logic        can_start;
    logic        writing_state;
    logic        fifo_push;
    logic        fifo_pop;
    logic [31:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    assign fmt   = op_format(req.op);
    assign legal = (fmt != FMT_ILLEGAL);
    assign word  = encode_word(fmt, req.op, req.rd, req.rs, req.rt, req.shamt,
                               req.aluop, req.imm, req.target);

    // Ready depends only on registered state, never on req_valid.
    assign req.req_ready = (state == ST_RUN) && !fifo_full && !acc_last;
    assign accept        = req.req_valid && req.req_ready;

    assign can_start     = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign writing_state = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_ERR);
    assign fifo_push     = accept && legal;
    assign fifo_pop      = !can_start && writing_state && !fifo_empty && !mem_hold;

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (can_start),
        .push  (fifo_push),
        .din   (word),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            acc_addr    <= '0;
            wr_addr     <= '0;
            acc_last    <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_data   <= '0;
            count       <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            imem_we <= fifo_pop;
            if (fifo_pop) begin
                imem_addr <= wr_addr;
                imem_data <= fifo_dout;
                wr_addr   <= wr_addr + ADDR_W'(1);
                count     <= count + (ADDR_W+1)'(1);
            end

            if (can_start) begin
                state       <= ST_RUN;
                acc_addr    <= base_addr;
                wr_addr     <= base_addr;
                acc_last    <= 1'b0;
                count       <= '0;
                done        <= 1'b0;
                err_illegal <= 1'b0;
                err_full    <= 1'b0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (accept && !legal) begin
                            err_illegal <= 1'b1;
                            state       <= ST_ERR;
                        end else begin
                            if (accept) begin
                                acc_addr <= acc_addr + ADDR_W'(1);
                                if (acc_addr == TOP_ADDR) begin
                                    acc_last <= 1'b1;
                                    err_full <= 1'b1;
                                end
                            end
                            // An accept coinciding with finish is kept; the word drains normally.
                            if (finish || (accept && acc_addr == TOP_ADDR)) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (fifo_empty) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with directed and random sessions
module tb_instr_encoder;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [16:0] imm;
        logic [26:0] target;
    } req_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              finish;
    logic              mem_hold;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_full;
    logic [ADDR_W:0]   count;

    instr_encoder_if req();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .finish      (finish),
        .req         (req),
        .mem_hold    (mem_hold),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal),
        .err_full    (err_full),
        .count       (count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    bit hold_rand = 0;
    bit m_stop = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [ADDR_W-1:0] q_addr [$];
    logic [31:0]       q_data [$];
    logic [4:0] legal_ops [11] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd1, 5'd3, 5'd22, 5'd21, 5'd4};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference word built straight from the format table with shifts and adds.
    function automatic logic [31:0] ref_word(input req_t r);
        logic [31:0] w;
        w = 32'(r.op) << 27;
        if (r.op == 5'd0)
            w = w + (32'(r.rd) << 22) + (32'(r.rs) << 17) + (32'(r.rt) << 12)
                  + (32'(r.shamt) << 7) + (32'(r.aluop) << 2);
        else if (r.op inside {5'd5, 5'd7, 5'd8, 5'd2, 5'd6})
            w = w + (32'(r.rd) << 22) + (32'(r.rs) << 17) + 32'(r.imm);
        else if (r.op inside {5'd1, 5'd3, 5'd22, 5'd21})
            w = w + 32'(r.target);
        else
            w = w + (32'(r.rd) << 22);
        return w;
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic req_t mk(input logic [4:0] op, rd, rs, rt, shamt, aluop,
                                input logic [16:0] imm, input logic [26:0] target);
        req_t r;
        r.op = op; r.rd = rd; r.rs = rs; r.rt = rt; r.shamt = shamt; r.aluop = aluop;
        r.imm = imm; r.target = target;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(legal_ops[$urandom_range(0, 10)], 5'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), 17'($urandom), 27'($urandom));
    endfunction

    task automatic model_accept(input req_t r, input logic [32:0] lit);
        if (m_stop) begin
            checks++;
            errors++;
            $display("FAIL accept_when_closed actual=accepted required=refused");
        end
        if (is_legal(r.op)) begin
            q_addr.push_back(m_addr);
            q_data.push_back(lit[32] ? lit[31:0] : ref_word(r));
            if (m_addr == {ADDR_W{1'b1}}) m_stop = 1;
            m_addr = m_addr + 1'b1;
        end else begin
            m_stop = 1;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (hold_rand) mem_hold = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send(input req_t r, input logic [32:0] lit, input int max_wait, output bit acc);
        acc = 0;
        for (int w = 0; w < max_wait && !acc; w++) begin
            tick();
            req.req_valid = 1'b1;
            req.op = r.op; req.rd = r.rd; req.rs = r.rs; req.rt = r.rt;
            req.shamt = r.shamt; req.aluop = r.aluop; req.imm = r.imm; req.target = r.target;
            if (req.req_ready === 1'b1) begin
                acc = 1;
                model_accept(r, lit);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            req.req_valid = 1'b0;
        end
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] base);
        tick();
        req.req_valid = 1'b0;
        start = 1'b1;
        base_addr = base;
        m_addr = base;
        m_stop = 0;
        exp_count = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic do_finish();
        tick();
        req.req_valid = 1'b0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            req.req_valid = 1'b0;
            n++;
        end
        check(name, done, 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_we"}, imem_we, 0);
        check({name, "_addr"}, imem_addr, 0);
        check({name, "_data"}, imem_data, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_errs"}, {err_illegal, err_full}, 0);
        check({name, "_count"}, count, 0);
        check({name, "_ready"}, req.req_ready, 0);
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    initial begin
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        forever begin
            @(negedge clock);
            if (imem_we === 1'b1) begin
                if (q_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h@%0h required=no_write", imem_data, imem_addr);
                end else begin
                    ea = q_addr.pop_front();
                    ed = q_data.pop_front();
                    exp_count++;
                    check("wr_addr", imem_addr, ea);
                    check("wr_data", imem_data, ed);
                    check("wr_count", count, exp_count);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        reset = 1'b1; start = 1'b0; finish = 1'b0; mem_hold = 1'b0; base_addr = '0;
        req.req_valid = 1'b0;
        req.op = '0; req.rd = '0; req.rs = '0; req.rt = '0;
        req.shamt = '0; req.aluop = '0; req.imm = '0; req.target = '0;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;

        // Directed encodings from the ISA table
        start_session(12'h000);
        check("busy_run", busy, 1);
        send(mk(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0), {1'b1, 32'h28400005}, 4, acc);
        check("accept_addi", acc, 1);
        idle(3);
        check("count_addi", count, 1);
        send(mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0), {1'b1, 32'h00C22000}, 4, acc);
        send(mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd1, 17'd0, 27'd0), {1'b1, 32'h00C22004}, 4, acc);
        send(mk(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h100), {1'b1, 32'h08000100}, 4, acc);
        send(mk(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h7FFFFFF), {1'b1, 32'h1FFFFFFF}, 4, acc);
        send(mk(5'b00100, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0), {1'b1, 32'h27C00000}, 4, acc);
        do_finish();
        wait_done("done_directed");
        check("count_directed", count, 6);
        check("busy_done", busy, 0);
        check("drained_directed", q_addr.size(), 0);

        // Back-pressure: FIFO fills to DEPTH while imem is held
        start_session(12'h000);
        mem_hold = 1'b1;
        n_acc = 0;
        repeat (8) begin
            send(rand_req(), 33'd0, 1, acc);
            if (acc) n_acc++;
        end
        check("hold_accepts", n_acc, DEPTH);
        check("hold_ready", req.req_ready, 0);
        check("hold_no_write", count, 0);
        tick();
        req.req_valid = 1'b0;
        mem_hold = 1'b0;
        repeat (4) tick();
        check("burst_count", count, 4);
        do_finish();
        wait_done("done_hold");
        check("drained_hold", q_addr.size(), 0);

        // Illegal opcode ends the session in ERR after draining legal words
        start_session(12'h000);
        send(rand_req(), 33'd0, 4, acc);
        send(rand_req(), 33'd0, 4, acc);
        send(mk(5'b11111, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 17'd6, 27'd7), 33'd0, 4, acc);
        check("accept_illegal", acc, 1);
        idle(8);
        check("err_illegal", err_illegal, 1);
        check("err_busy", busy, 0);
        check("err_done", done, 0);
        check("err_ready", req.req_ready, 0);
        check("err_count", count, 2);
        check("drained_err", q_addr.size(), 0);
        start_session(12'h010);
        check("restart_clears_err", err_illegal, 0);
        check("restart_busy", busy, 1);
        do_finish();
        wait_done("done_restart");

        // Top of imem reached
        start_session(12'hFFE);
        send(rand_req(), 33'd0, 4, acc);
        check("full_acc0", acc, 1);
        send(rand_req(), 33'd0, 4, acc);
        check("full_acc1", acc, 1);
        send(rand_req(), 33'd0, 4, acc);
        check("full_refused", acc, 0);
        wait_done("done_full");
        check("err_full", err_full, 1);
        check("count_full", count, 2);
        check("drained_full", q_addr.size(), 0);

        // Random traffic with random mem_hold and request gaps
        hold_rand = 1;
        start_session(12'($urandom_range(0, 12'hE00)));
        for (int i = 0; i < 200 && !m_stop; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else send(rand_req(), 33'd0, 20, acc);
        end
        do_finish();
        wait_done("done_random");
        hold_rand = 0;
        mem_hold = 1'b0;
        check("drained_random", q_addr.size(), 0);
        check("count_random", count, exp_count);

        // Reset mid-session discards queued words
        start_session(12'h000);
        mem_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(rand_req(), 33'd0, 4, acc);
            check("mid_accept", acc, 1);
        end
        tick();
        req.req_valid = 1'b0;
        reset = 1'b1;
        q_addr.delete();
        q_data.delete();
        exp_count = 0;
        tick();
        mem_hold = 1'b0;
        check("rst_we0", imem_we, 0);
        repeat (4) begin
            tick();
            check("rst_we_hold", imem_we, 0);
        end
        reset = 1'b0;
        repeat (4) begin
            tick();
            check("post_rst_we", imem_we, 0);
        end
        check_idle_outputs("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
